// File: rtl/booth_mult4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult4_pkg
// Description : Shared definitions for the radix-2 Booth multiplier:
//               default operand width, step-counter width and the FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mult4_pkg;

    // Default operand width in bits; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 4;

    // The step counter must hold the value WIDTH-1 with headroom to spare.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : booth_mult4_pkg
`default_nettype wire

// File: rtl/booth_mult4_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult4_if
// Description : Request/response bundle of the Booth multiplier.
//               start/a/b      - request (master drives)
//               busy/done/p    - status and result (slave drives)
//               master modport : requester side
//               slave modport  : multiplier side
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult4_if
    import booth_mult4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  p
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output p
    );

endinterface : booth_mult4_if
`default_nettype wire

// File: rtl/booth_mult4_addsub.sv
`default_nettype none
// ============================================================================
// Module      : addsub_stage
// Description : Combinational N-bit adder/subtractor with wrap-around.
//               sum = x + y when sub = 0, sum = x - y when sub = 1.
//               Ports: x, y (N bits), sub (1 bit), sum (N bits).
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_stage #(
    parameter int N = 5
) (
    input  wire logic [N-1:0] x,
    input  wire logic [N-1:0] y,
    input  wire logic         sub,
    output logic      [N-1:0] sum
);

    // Two's-complement subtract: invert y and inject a carry-in of one.
    logic [N-1:0] w_y_mod;
    logic [N-1:0] w_cin;

    assign w_y_mod = y ^ {N{sub}};
    assign w_cin   = {{(N-1){1'b0}}, sub};
    assign sum     = x + w_y_mod + w_cin;

endmodule : addsub_stage
`default_nettype wire

// File: rtl/booth_mult4.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult4
// Description : Sequential radix-2 Booth multiplier for signed operands.
//               One Booth step per cycle, WIDTH steps per product.
//               clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of booth_mult4_if
//                        (start/a/b in, busy/done/p out)
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult4
    import booth_mult4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    booth_mult4_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    logic [WIDTH:0]       r_acc;   // accumulator A, one guard bit wider
    logic [WIDTH-1:0]     r_q;     // multiplier Q, consumed LSB first
    logic                 r_q1;    // Booth look-behind bit
    logic [WIDTH:0]       r_m;     // sign-extended multiplicand
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_sub;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_acc_step;
    logic [WIDTH:0]       w_acc_sh;
    logic [WIDTH-1:0]     w_q_sh;
    logic                 w_last;

    // {Q0,q_1} = 10 subtracts M, 01 adds M, equal bits leave A alone.
    assign w_sub = r_q[0] & ~r_q1;

    addsub_stage #(
        .N   (WIDTH + 1)
    ) u_addsub (
        .x   (r_acc),
        .y   (r_m),
        .sub (w_sub),
        .sum (w_sum)
    );

    assign w_acc_step = (r_q[0] ^ r_q1) ? w_sum : r_acc;

    // Arithmetic right shift of {A,Q,q_1}; A's sign bit is replicated.
    assign w_acc_sh = {w_acc_step[WIDTH], w_acc_step[WIDTH:1]};
    assign w_q_sh   = {w_acc_step[0], r_q[WIDTH-1:1]};

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_q     <= bus.b;
                        r_q1    <= 1'b0;
                        r_m     <= {bus.a[WIDTH-1], bus.a};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    r_acc <= w_acc_sh;
                    r_q   <= w_q_sh;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Product is taken from the post-shift value of
                        // the final step, so it is valid with done.
                        r_p     <= {w_acc_sh[WIDTH-1:0], w_q_sh};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.p    = r_p;

endmodule : booth_mult4
`default_nettype wire

// File: tb/tb_booth_mult4.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult4
// Description : Self-checking bench for booth_mult4. Stimulus pushes the
//               expected product into a queue; a monitor pops and compares
//               on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult4;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_mult4_if #(.WIDTH(W)) bus ();

    booth_mult4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [2*W-1:0] exp_q[$];
    int             done_cyc[$];
    int             checks = 0;
    int             errors = 0;
    int             n_done = 0;
    int             cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending product.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (bus.done === 1'b1) begin
            n_done++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: p=0x%0h with no result pending", bus.p);
            end else begin
                e = exp_q.pop_front();
                check("product", {24'd0, bus.p}, {24'd0, e});
            end
        end
    end

    // Drive a one-cycle start pulse; returns at the negedge after acceptance.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20 && n_done < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done count %0d, expected %0d", n_done, target);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2*W-1:0] e);
        int tgt;
        tgt = n_done + 1;
        exp_q.push_back(e);
        start_op(ia, ib);
        wait_done(tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   va [4];
        logic [W-1:0]   vb [4];
        logic [2*W-1:0] vp [4];
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] sp;
        int tgt;
        int nd;

        va = '{4'hD, 4'h7, 4'h8, 4'h0};
        vb = '{4'h5, 4'h8, 4'h8, 4'hF};
        vp = '{8'hF1, 8'hC8, 8'h40, 8'h00};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_p", {24'd0, bus.p}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 3*5 with cycle-exact latency and busy window
        exp_q.push_back(8'h0F);
        tgt = n_done + 1;
        start_op(4'd3, 4'd5);
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("busy_window", {31'd0, bus.busy}, 32'd1);
            check("done_early", {31'd0, bus.done}, 32'd0);
            @(negedge clk);
            #1;
        end
        check("done_latency", {31'd0, bus.done}, 32'd1);
        check("busy_in_done", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        #1;
        check("done_pulse_width", {31'd0, bus.done}, 32'd0);
        check("p_held", {24'd0, bus.p}, 32'h0F);
        check("done_count_3x5", n_done, tgt);

        // Signed directed vectors, including -8 * -8
        for (int i = 0; i < 4; i++) run_op(va[i], vb[i], vp[i]);

        // Start re-pulsed while busy is ignored
        exp_q.push_back(8'h0C);
        tgt = n_done + 1;
        start_op(4'd2, 4'd6);
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt);
        repeat (10) @(negedge clk);
        #1;
        check("single_done_on_restart", n_done, tgt);

        // Reset in the second busy cycle aborts the operation
        nd = n_done;
        start_op(4'd5, 4'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_p", {24'd0, bus.p}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("abort_no_done", n_done, nd);
        check("idle_after_reset", {31'd0, bus.busy}, 32'd0);
        run_op(4'd2, 4'd3, 8'h06);

        // Back-to-back with start held high
        tgt = n_done + 3;
        exp_q.push_back(8'h01);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'h1;
        bus.b     = 4'h1;
        @(negedge clk);
        exp_q.push_back(8'hFC);
        bus.a = 4'h2;
        bus.b = 4'hE;
        repeat (6) @(negedge clk);
        exp_q.push_back(8'h01);
        bus.a = 4'hF;
        bus.b = 4'hF;
        repeat (6) @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt);
        if (done_cyc.size() >= 3) begin
            check("b2b_period_1", done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3], 6);
            check("b2b_period_2", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 6);
        end

        // All operand pairs against a signed multiply model
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = 4'(i);
                sb = 4'(j);
                sp = sa * sb;
                run_op(4'(i), 4'(j), sp);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_booth_mult4
`default_nettype wire
